// File: rtl/branch_target_unit.sv
// rtl/branch_target_unit.sv - registered jal/jalr/branch target unit with return-address stack
module branch_target_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int IALIGN    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   op,
    input  logic [XLEN-1:0]              pc,
    input  logic [XLEN-1:0]              imm,
    input  logic [XLEN-1:0]              rs1,
    input  logic                         rd_link,
    input  logic                         rs1_link,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              target,
    output logic [XLEN-1:0]              link_addr,
    output logic                         misaligned,
    output logic                         ras_pred_valid,
    output logic [XLEN-1:0]              ras_pred,
    output logic                         ras_hit,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AL_W  = $clog2(IALIGN);

    localparam logic [1:0] OP_JAL  = 2'b00;
    localparam logic [1:0] OP_JALR = 2'b01;
    localparam logic [1:0] OP_SEQ  = 2'b11;

    logic                valid_q, valid_d;
    logic [XLEN-1:0]     target_q, target_d;
    logic [XLEN-1:0]     link_q, link_d;
    logic                mis_q, mis_d;
    logic                pred_valid_q, pred_valid_d;
    logic [XLEN-1:0]     pred_q, pred_d;
    logic                hit_q, hit_d;

    logic [XLEN-1:0]     ras_q [RAS_DEPTH];
    logic [XLEN-1:0]     ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]    wp_q, wp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [XLEN-1:0]     link;
    logic [XLEN-1:0]     tgt;
    logic                mis;
    logic                do_pop, do_push, pop_ok;
    logic [PTR_W-1:0]    top_idx;
    logic [XLEN-1:0]     pred;
    logic [PTR_W-1:0]    wp_mid;
    logic [CNT_W-1:0]    cnt_mid;

    assign in_ready       = !valid_q || out_ready;
    assign out_valid      = valid_q;
    assign target         = target_q;
    assign link_addr      = link_q;
    assign misaligned     = mis_q;
    assign ras_pred_valid = pred_valid_q;
    assign ras_pred       = pred_q;
    assign ras_hit        = hit_q;
    assign ras_count      = cnt_q;

    always_comb begin
        accept = in_valid && in_ready;
        link   = pc + XLEN'(4);

        case (op)
            OP_JALR: tgt = (rs1 + imm) & ~XLEN'(1);
            OP_SEQ:  tgt = link;
            default: tgt = pc + imm;
        endcase

        mis = (op != OP_SEQ) && (tgt[AL_W-1:0] != '0);

        do_pop  = (op == OP_JALR) && rs1_link;
        do_push = rd_link && ((op == OP_JAL) || (op == OP_JALR));
        pop_ok  = do_pop && (cnt_q != '0);
        top_idx = wp_q - PTR_W'(1);
        pred    = pop_ok ? ras_q[top_idx] : '0;
    end

    always_comb begin
        valid_d      = valid_q && !out_ready;
        target_d     = target_q;
        link_d       = link_q;
        mis_d        = mis_q;
        pred_valid_d = pred_valid_q;
        pred_d       = pred_q;
        hit_d        = hit_q;
        ras_d        = ras_q;
        wp_d         = wp_q;
        cnt_d        = cnt_q;
        wp_mid       = wp_q;
        cnt_mid      = cnt_q;

        if (accept) begin
            valid_d      = 1'b1;
            target_d     = tgt;
            link_d       = link;
            mis_d        = mis;
            pred_valid_d = pop_ok;
            pred_d       = pred;
            hit_d        = pop_ok && (pred == tgt);

            // Pop first; a same-cycle push then lands in the freed slot.
            if (pop_ok) begin
                wp_mid  = top_idx;
                cnt_mid = cnt_q - CNT_W'(1);
            end
            wp_d  = wp_mid;
            cnt_d = cnt_mid;
            // Pointer wraps, so a push when full replaces the oldest entry.
            if (do_push) begin
                ras_d[wp_mid] = link;
                wp_d          = wp_mid + PTR_W'(1);
                cnt_d         = (cnt_mid == CNT_W'(RAS_DEPTH)) ? cnt_mid : cnt_mid + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            mis_q        <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_q       <= '0;
            hit_q        <= 1'b0;
            wp_q         <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            target_q     <= target_d;
            link_q       <= link_d;
            mis_q        <= mis_d;
            pred_valid_q <= pred_valid_d;
            pred_q       <= pred_d;
            hit_q        <= hit_d;
            wp_q         <= wp_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
// tb/tb_branch_target_unit.sv - self-checking bench for branch_target_unit
module tb_branch_target_unit;

    localparam int DEPTH = 4;
    localparam logic [1:0] JAL = 2'b00, JALR = 2'b01, BR = 2'b10, SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, rd_link, rs1_link;
    logic [1:0]  op;
    logic [31:0] pc, imm, rs1;
    logic        in_ready, out_valid, misaligned, ras_pred_valid, ras_hit;
    logic [31:0] target, link_addr, ras_pred;
    logic [2:0]  ras_count;

    logic        d2_in_ready, d2_out_valid, d2_mis, d2_pv, d2_hit;
    logic [31:0] d2_target, d2_link, d2_pred;
    logic [2:0]  d2_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_target_unit #(.XLEN(32), .RAS_DEPTH(DEPTH), .IALIGN(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .pc(pc), .imm(imm), .rs1(rs1), .rd_link(rd_link), .rs1_link(rs1_link),
        .out_valid(out_valid), .out_ready(out_ready), .target(target),
        .link_addr(link_addr), .misaligned(misaligned), .ras_pred_valid(ras_pred_valid),
        .ras_pred(ras_pred), .ras_hit(ras_hit), .ras_count(ras_count)
    );

    branch_target_unit #(.XLEN(32), .RAS_DEPTH(DEPTH), .IALIGN(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .op(op),
        .pc(pc), .imm(imm), .rs1(rs1), .rd_link(rd_link), .rs1_link(rs1_link),
        .out_valid(d2_out_valid), .out_ready(out_ready), .target(d2_target),
        .link_addr(d2_link), .misaligned(d2_mis), .ras_pred_valid(d2_pv),
        .ras_pred(d2_pred), .ras_hit(d2_hit), .ras_count(d2_count)
    );

    // Reference model: result register contents plus the RAS as a bounded queue.
    logic [31:0] ras_m[$];
    logic        e_valid, e_mis, e_mis2, e_pv, e_hit, rdy_obs, rdy_exp;
    logic [31:0] e_target, e_link, e_pred;

    function automatic logic [104:0] obs_vec();
        return {rdy_obs, out_valid, target, link_addr, misaligned, d2_mis,
                ras_pred_valid, ras_pred, ras_hit, ras_count};
    endfunction

    function automatic logic [104:0] exp_vec();
        logic [2:0] c;
        c = 3'(ras_m.size());
        return {rdy_exp, e_valid, e_target, e_link, e_mis, e_mis2, e_pv, e_pred, e_hit, c};
    endfunction

    task automatic model_reset();
        ras_m.delete();
        e_valid = 0; e_mis = 0; e_mis2 = 0; e_pv = 0; e_hit = 0;
        e_target = 0; e_link = 0; e_pred = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [1:0] o, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] r, input logic rdl, input logic r1l, input logic ordy);
        logic [31:0] t;
        in_valid = v; op = o; pc = p; imm = i; rs1 = r;
        rd_link = rdl; rs1_link = r1l; out_ready = ordy;
        #1;
        rdy_obs = in_ready;
        rdy_exp = !e_valid || ordy;
        if (v && rdy_exp) begin
            if (o == JALR)     t = (r + i) & 32'hFFFF_FFFE;
            else if (o == SEQ) t = p + 4;
            else               t = p + i;
            e_valid  = 1;
            e_target = t;
            e_link   = p + 4;
            e_mis    = (o != SEQ) && (t % 4 != 0);
            e_mis2   = (o != SEQ) && (t % 2 != 0);
            e_pv     = 0;
            e_pred   = 0;
            if (o == JALR && r1l && ras_m.size() > 0) begin
                e_pv   = 1;
                e_pred = ras_m.pop_back();
            end
            if (rdl && (o == JAL || o == JALR)) begin
                ras_m.push_back(p + 4);
                if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
            end
            e_hit = e_pv && (e_pred == t);
        end else if (ordy) begin
            e_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if ({in_ready, out_valid, ras_count, target, ras_pred_valid} !== {1'b1, 1'b0, 3'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b vld=%b cnt=%0d tgt=%h want 1 0 0 0", in_ready, out_valid, ras_count, target);
        end
    endtask

    task automatic test_jal();
        step(1, JAL, 32'h100, 32'h20, $urandom, 1, 0, 1);
        n_tests++;
        if (obs_vec() !== exp_vec() || target !== 32'h120 || link_addr !== 32'h104 || ras_count !== 3'd1) begin
            n_fail++;
            $display("FAIL jal: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_jalr_align();
        step(1, JALR, 32'h400, 32'h2, 32'h1001, 0, 0, 1);
        n_tests++;
        if (obs_vec() !== exp_vec() || target !== 32'h1002 || misaligned !== 1'b1 || d2_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_align: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ras_overflow();
        for (int k = 1; k <= 5; k++) begin
            step(1, JAL, 32'(k * 16), 32'($urandom_range(0, 255)) << 2, $urandom, 1, 0, 1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ras_push%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(1, JALR, $urandom, 32'h0, $urandom & 32'hFFFF_FFFC, 0, 1, 1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ras_pop%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ras_hit();
        step(1, JAL, 32'h200, 32'h40, $urandom, 1, 0, 1);
        step(1, JALR, 32'h240, 32'h0, 32'h204, 0, 1, 1);
        n_tests++;
        if (obs_vec() !== exp_vec() || ras_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_hit: got %h want %h", obs_vec(), exp_vec());
        end
        step(1, JAL, 32'h300, 32'h40, $urandom, 1, 0, 1);
        step(1, JALR, 32'h340, 32'h4, 32'h304, 0, 1, 1);
        n_tests++;
        if (obs_vec() !== exp_vec() || ras_hit !== 1'b0 || ras_pred_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_miss: got %h want %h", obs_vec(), exp_vec());
        end
        step(1, JAL, 32'h500, 32'h8, $urandom, 1, 0, 1);
        step(1, JALR, 32'h600, 32'h0, 32'h504, 1, 1, 1);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ras_pop_push: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        step(1, JAL, 32'h800, 32'h10, $urandom, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 2'($urandom), $urandom, $urandom, $urandom, 1, 1, 0);
            n_tests++;
            if (obs_vec() !== exp_vec() || rdy_obs !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 2'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'($urandom), 1'($urandom), 1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] p, i, r;
        for (int k = 0; k < 300; k++) begin
            p = ($urandom % 2) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            i = 32'($signed(12'($urandom)));
            r = $urandom;
            if (ras_m.size() > 0 && $urandom % 2) r = ras_m[$] - i;
            step(1'($urandom), 2'($urandom), p, i, r, 1'($urandom), 1'($urandom), ($urandom % 4) != 0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, JAL, 32'h900, 32'h10, $urandom, 1, 0, 0);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, ras_count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got vld=%b cnt=%0d rdy=%b want 0 0 1", out_valid, ras_count, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, BR, 32'hFFFF_FFFC, 32'h8, $urandom, 0, 0, 1);
        n_tests++;
        if (obs_vec() !== exp_vec() || target !== 32'h4 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; out_ready = 0; op = 0; pc = 0; imm = 0; rs1 = 0; rd_link = 0; rs1_link = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_jal();
        test_jalr_align();
        test_ras_overflow();
        test_ras_hit();
        test_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
